// File: rtl/avalon_arbiter_mux.sv
// avalon_arbiter_mux: shares one Avalon-MM slave port between NUM_MASTERS masters.
// The arbiter grants one master at a time, passes its command through, locks the
// grant for the remaining beats of a write burst, and tracks issued read bursts
// in a small FIFO so that returning read beats reach the master that asked for them.
// Optional build macro AVARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of the default round-robin arbitration.
module avalon_arbiter_mux #(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_PENDING = 4
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_n,
    input  logic [30*NUM_MASTERS-1:0]   i_AVIn_Addr,
    input  logic [4*NUM_MASTERS-1:0]    i_AVIn_ByteEn,
    input  logic [NUM_MASTERS-1:0]      i_AVIn_Read,
    input  logic [NUM_MASTERS-1:0]      i_AVIn_Write,
    input  logic [32*NUM_MASTERS-1:0]   i_AVIn_WriteData,
    input  logic [8*NUM_MASTERS-1:0]    i_AVIn_BurstCount,
    output logic [32*NUM_MASTERS-1:0]   o_AVIn_ReadData,
    output logic [NUM_MASTERS-1:0]      o_AVIn_ReadDataValid,
    output logic [NUM_MASTERS-1:0]      o_AVIn_WaitRequest,
    output logic [29:0]                 o_AVOut_Addr,
    output logic [3:0]                  o_AVOut_ByteEn,
    output logic                        o_AVOut_Read,
    output logic                        o_AVOut_Write,
    output logic [31:0]                 o_AVOut_WriteData,
    output logic [7:0]                  o_AVOut_BurstCount,
    input  logic [31:0]                 i_AVOut_ReadData,
    input  logic                        i_AVOut_ReadDataValid,
    input  logic                        i_AVOut_WaitRequest
);

    localparam int MW = $clog2(NUM_MASTERS);
    localparam int PW = $clog2(MAX_PENDING);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
    localparam logic [1:0] S_WBURST = 2'd2;

    logic [1:0]     r_State;
    logic [MW-1:0]  r_Grant;
    logic [MW-1:0]  r_LastGrant;
    logic [7:0]     r_WBeats;

    // Pending read bursts: issuing master and burst length, oldest at r_Head.
    logic [MW-1:0]  r_FifoMaster [MAX_PENDING];
    logic [7:0]     r_FifoBurst  [MAX_PENDING];
    logic [PW-1:0]  r_Head;
    logic [PW-1:0]  r_Tail;
    logic [PW:0]    r_Count;
    logic [7:0]     r_HeadRcvd;

    logic [NUM_MASTERS-1:0] w_Req;
    logic [MW-1:0]  w_Winner;
    logic [MW-1:0]  w_Cand;
    logic           w_Found;
    logic           w_Active;
    logic           w_GRead;
    logic           w_GWrite;
    logic [7:0]     w_GBurst;
    logic [7:0]     w_GBurstN;
    logic           w_Full;
    logic           w_ReadBlock;
    logic           w_RdAcc;
    logic           w_WrAcc;
    logic           w_Push;
    logic           w_Pop;
    logic           w_RdValid;
    logic [MW-1:0]  w_HeadMaster;

    assign w_Req = i_AVIn_Read | i_AVIn_Write;

    // Pick the next master to grant from the current request vector.
    always_comb begin
        w_Winner = '0;
        w_Cand   = '0;
        w_Found  = 1'b0;
`ifdef AVARB_FIXED_PRIO_EN
        // Descending scan so the lowest requesting index is the last to overwrite.
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            w_Cand = MW'(i);
            if (w_Req[w_Cand]) begin
                w_Winner = w_Cand;
                w_Found  = 1'b1;
            end
        end
`else
        // Descending distance from the last grant: the nearest requester after it wins.
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            w_Cand = MW'((int'(r_LastGrant) + i) % NUM_MASTERS);
            if (w_Req[w_Cand]) begin
                w_Winner = w_Cand;
                w_Found  = 1'b1;
            end
        end
`endif
    end

    assign w_Active    = (r_State != S_IDLE);
    assign w_GRead     = i_AVIn_Read[r_Grant];
    assign w_GWrite    = i_AVIn_Write[r_Grant];
    assign w_GBurst    = i_AVIn_BurstCount[8*r_Grant +: 8];
    assign w_GBurstN   = (w_GBurst == 8'd0) ? 8'd1 : w_GBurst;
    assign w_Full      = (r_Count == (PW+1)'(MAX_PENDING));
    // A new read cannot be issued when there is no room to remember its owner.
    assign w_ReadBlock = (r_State == S_GRANT) && w_GRead && w_Full;
    assign w_RdAcc     = (r_State == S_GRANT) && w_GRead && !w_Full && !i_AVOut_WaitRequest;
    assign w_WrAcc     = w_Active && w_GWrite && !w_ReadBlock && !i_AVOut_WaitRequest && !w_RdAcc;
    assign w_Push      = w_RdAcc;

    assign o_AVOut_Addr       = i_AVIn_Addr[30*r_Grant +: 30];
    assign o_AVOut_ByteEn     = i_AVIn_ByteEn[4*r_Grant +: 4];
    assign o_AVOut_WriteData  = i_AVIn_WriteData[32*r_Grant +: 32];
    assign o_AVOut_BurstCount = w_GBurst;
    assign o_AVOut_Read       = w_Active && w_GRead && !w_ReadBlock;
    assign o_AVOut_Write      = w_Active && w_GWrite;

    // Only the granted master can see the slave's stall; everyone else waits.
    always_comb begin
        o_AVIn_WaitRequest = '1;
        if (w_Active) begin
            o_AVIn_WaitRequest[r_Grant] = i_AVOut_WaitRequest | w_ReadBlock;
        end
    end

    assign o_AVIn_ReadData = {NUM_MASTERS{i_AVOut_ReadData}};
    assign w_RdValid       = i_AVOut_ReadDataValid && (r_Count != '0);
    assign w_HeadMaster    = r_FifoMaster[r_Head];
    assign w_Pop           = w_RdValid && ((r_HeadRcvd + 8'd1) == r_FifoBurst[r_Head]);

    // Route a returning read beat to the owner of the oldest pending burst.
    always_comb begin
        o_AVIn_ReadDataValid = '0;
        if (w_RdValid) begin
            o_AVIn_ReadDataValid[w_HeadMaster] = 1'b1;
        end
    end

    // Grant state machine: arbitrate in IDLE, transfer in GRANT, hold for write bursts.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State     <= S_IDLE;
            r_Grant     <= '0;
            r_LastGrant <= MW'(NUM_MASTERS - 1);
            r_WBeats    <= '0;
        end else begin
            case (r_State)
                S_IDLE: begin
                    if (w_Found) begin
                        r_Grant     <= w_Winner;
                        r_LastGrant <= w_Winner;
                        r_State     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!w_GRead && !w_GWrite) begin
                        r_State <= S_IDLE;
                    end else if (w_RdAcc) begin
                        r_State <= S_IDLE;
                    end else if (w_WrAcc) begin
                        if (w_GBurstN == 8'd1) begin
                            r_State <= S_IDLE;
                        end else begin
                            r_WBeats <= w_GBurstN - 8'd1;
                            r_State  <= S_WBURST;
                        end
                    end
                end
                S_WBURST: begin
                    if (w_WrAcc) begin
                        r_WBeats <= r_WBeats - 8'd1;
                        if (r_WBeats == 8'd1) begin
                            r_State <= S_IDLE;
                        end
                    end
                end
                default: r_State <= S_IDLE;
            endcase
        end
    end

    // Pending-read FIFO pointers, occupancy and head beat count.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Head     <= '0;
            r_Tail     <= '0;
            r_Count    <= '0;
            r_HeadRcvd <= '0;
        end else begin
            if (w_Push) begin
                r_Tail <= r_Tail + 1'b1;
            end
            if (w_Pop) begin
                r_Head <= r_Head + 1'b1;
            end
            r_Count <= r_Count + (PW+1)'(w_Push) - (PW+1)'(w_Pop);
            if (w_RdValid) begin
                r_HeadRcvd <= w_Pop ? 8'd0 : (r_HeadRcvd + 8'd1);
            end
        end
    end

    // Pending-read FIFO storage; contents are only meaningful below r_Count.
    always_ff @(posedge i_Clk) begin
        if (w_Push) begin
            r_FifoMaster[r_Tail] <= r_Grant;
            r_FifoBurst[r_Tail]  <= w_GBurstN;
        end
    end

endmodule

// File: tb/tb_avalon_arbiter_mux.sv
// tb_avalon_arbiter_mux: random Avalon masters and a random slave drive the
// arbiter; a transaction-level reference model predicts every output each cycle.
module tb_avalon_arbiter_mux;

    localparam int NM   = 3;
    localparam int MP   = 4;
    localparam int NCYC = 2200;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [30*NM-1:0]   av_addr = '0;
    logic [4*NM-1:0]    av_be = '0;
    logic [NM-1:0]      av_rd = '0;
    logic [NM-1:0]      av_wr = '0;
    logic [32*NM-1:0]   av_wd = '0;
    logic [8*NM-1:0]    av_bc = '0;
    logic [32*NM-1:0]   av_rdata;
    logic [NM-1:0]      av_rdv;
    logic [NM-1:0]      av_wait;
    logic [29:0]        s_addr;
    logic [3:0]         s_be;
    logic               s_rd;
    logic               s_wr;
    logic [31:0]        s_wd;
    logic [7:0]         s_bc;
    logic [31:0]        s_rdata = '0;
    logic               s_rdv = 1'b0;
    logic               s_wait = 1'b0;

    avalon_arbiter_mux #(.NUM_MASTERS(NM), .MAX_PENDING(MP)) dut (
        .i_Clk                (clk),
        .i_Rst_n              (rst_n),
        .i_AVIn_Addr          (av_addr),
        .i_AVIn_ByteEn        (av_be),
        .i_AVIn_Read          (av_rd),
        .i_AVIn_Write         (av_wr),
        .i_AVIn_WriteData     (av_wd),
        .i_AVIn_BurstCount    (av_bc),
        .o_AVIn_ReadData      (av_rdata),
        .o_AVIn_ReadDataValid (av_rdv),
        .o_AVIn_WaitRequest   (av_wait),
        .o_AVOut_Addr         (s_addr),
        .o_AVOut_ByteEn       (s_be),
        .o_AVOut_Read         (s_rd),
        .o_AVOut_Write        (s_wr),
        .o_AVOut_WriteData    (s_wd),
        .o_AVOut_BurstCount   (s_bc),
        .i_AVOut_ReadData     (s_rdata),
        .i_AVOut_ReadDataValid(s_rdv),
        .i_AVOut_WaitRequest  (s_wait)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Behavioural masters
    bit          m_active [NM];
    bit          m_isw    [NM];
    int          m_left   [NM];
    logic [7:0]  m_bc     [NM];
    logic [29:0] m_addr   [NM];
    logic [3:0]  m_be     [NM];
    logic [31:0] m_wd     [NM];
    bit          acc      [NM];

    // Slave and traffic shaping
    int slave_beats = 0;
    int wait_pct = 25;
    int read_pct = 50;
    int max_wbc  = 4;
    bit hold_rdv = 0;
    bit stray    = 0;
    bit gen_en   = 1;

    // Reference model: current owner (-1 when nobody holds the port), the
    // remaining write beats of a locked burst, the last grant, and the queue of
    // outstanding read bursts as (owner, beats still to come).
    int mdl_owner = -1;
    int mdl_wleft = 0;
    int mdl_last  = NM - 1;
    int pend_m[$];
    int pend_left[$];

    function automatic int norm_bc(input logic [7:0] bc);
        return (bc == 8'd0) ? 1 : int'(bc);
    endfunction

    function automatic int pick(input logic [NM-1:0] req, input int last);
        int w;
        w = -1;
`ifdef AVARB_FIXED_PRIO_EN
        for (int i = NM - 1; i >= 0; i--) begin
            if (req[i]) w = i;
        end
`else
        for (int i = NM; i >= 1; i--) begin
            if (req[(last + i) % NM]) w = (last + i) % NM;
        end
`endif
        return w;
    endfunction

    task automatic model_reset();
        mdl_owner = -1;
        mdl_wleft = 0;
        mdl_last  = NM - 1;
        pend_m.delete();
        pend_left.delete();
    endtask

    task automatic drive_pins();
        for (int m = 0; m < NM; m++) begin
            av_rd[m]            = m_active[m] && !m_isw[m];
            av_wr[m]            = m_active[m] && m_isw[m];
            av_addr[30*m +: 30] = m_addr[m];
            av_be[4*m +: 4]     = m_be[m];
            av_wd[32*m +: 32]   = m_wd[m];
            av_bc[8*m +: 8]     = m_bc[m];
        end
    endtask

    task automatic drive_cycle();
        for (int m = 0; m < NM; m++) begin
            if (!rst_n) begin
                m_active[m] = 0;
            end else if (m_active[m] && acc[m]) begin
                if (m_isw[m] && m_left[m] > 1) begin
                    m_left[m]--;
                    m_wd[m] = $urandom;
                    m_be[m] = 4'($urandom);
                end else begin
                    m_active[m] = 0;
                end
            end
            if (!m_active[m] && gen_en && ($urandom_range(0, 99) < 60)) begin
                m_active[m] = 1;
                m_isw[m]    = ($urandom_range(0, 99) >= read_pct);
                m_bc[m]     = m_isw[m] ? 8'($urandom_range(0, max_wbc)) : 8'($urandom_range(0, 3));
                m_left[m]   = norm_bc(m_bc[m]);
                m_addr[m]   = 30'($urandom);
                m_be[m]     = 4'($urandom);
                m_wd[m]     = $urandom;
            end
        end
        drive_pins();
        s_wait  = ($urandom_range(0, 99) < wait_pct);
        s_rdata = $urandom;
        if (stray) begin
            s_rdv = 1'b1;
        end else if (!hold_rdv && slave_beats > 0 && ($urandom_range(0, 3) != 0)) begin
            s_rdv = 1'b1;
            slave_beats--;
        end else begin
            s_rdv = 1'b0;
        end
    endtask

    task automatic check_and_step();
        logic [NM-1:0] e_wait, e_rdv, req;
        bit e_rd, e_wr, full, block;
        int g;
        g     = mdl_owner;
        full  = (pend_m.size() == MP);
        block = (g >= 0) && (mdl_wleft == 0) && av_rd[g] && full;
        e_wait = '1;
        if (g >= 0) e_wait[g] = s_wait | block;
        e_rd = (g >= 0) && av_rd[g] && !block;
        e_wr = (g >= 0) && av_wr[g];
        e_rdv = '0;
        if (s_rdv && pend_m.size() > 0) e_rdv[pend_m[0]] = 1'b1;

        check_eq("waitrequest", 64'(av_wait), 64'(e_wait));
        check_eq("readdatavalid", 64'(av_rdv), 64'(e_rdv));
        check_eq("slave_read", 64'(s_rd), 64'(e_rd));
        check_eq("slave_write", 64'(s_wr), 64'(e_wr));
        for (int m = 0; m < NM; m++) begin
            check_eq("readdata_lane", 64'(av_rdata[32*m +: 32]), 64'(s_rdata));
        end
        if (g >= 0) begin
            check_eq("slave_addr", 64'(s_addr), 64'(m_addr[g]));
            check_eq("slave_byteen", 64'(s_be), 64'(m_be[g]));
            check_eq("slave_wdata", 64'(s_wd), 64'(m_wd[g]));
            check_eq("slave_burst", 64'(s_bc), 64'(m_bc[g]));
        end

        for (int m = 0; m < NM; m++) acc[m] = rst_n && m_active[m] && !av_wait[m];

        if (!rst_n) begin
            model_reset();
            slave_beats = 0;
            return;
        end

        if (s_rd && !s_wait) slave_beats += norm_bc(s_bc);

        // Read return against the oldest outstanding burst.
        if (s_rdv && pend_m.size() > 0) begin
            pend_left[0] = pend_left[0] - 1;
            if (pend_left[0] == 0) begin
                void'(pend_m.pop_front());
                void'(pend_left.pop_front());
            end
        end

        req = av_rd | av_wr;
        if (g < 0) begin
            if (req != '0) begin
                mdl_owner = pick(req, mdl_last);
                mdl_last  = mdl_owner;
            end
        end else if (mdl_wleft == 0) begin
            if (!av_rd[g] && !av_wr[g]) begin
                mdl_owner = -1;
            end else if (av_rd[g] && !e_wait[g]) begin
                pend_m.push_back(g);
                pend_left.push_back(norm_bc(m_bc[g]));
                mdl_owner = -1;
            end else if (av_wr[g] && !e_wait[g]) begin
                if (norm_bc(m_bc[g]) <= 1) mdl_owner = -1;
                else mdl_wleft = norm_bc(m_bc[g]) - 1;
            end
        end else begin
            if (av_wr[g] && !e_wait[g]) begin
                mdl_wleft--;
                if (mdl_wleft == 0) mdl_owner = -1;
            end
        end
    endtask

    initial begin
        for (int m = 0; m < NM; m++) begin
            m_active[m] = 0; m_isw[m] = 0; m_left[m] = 0; m_bc[m] = '0;
            m_addr[m] = '0; m_be[m] = '0; m_wd[m] = '0; acc[m] = 0;
        end
        model_reset();
        stray = 1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            // Traffic phases: mixed, read-return withheld, no-wait, long writes,
            // reset in the middle of write bursts with stray read beats, mixed.
            if (cyc == 4)    begin stray = 0; end
            if (cyc == 700)  begin hold_rdv = 1; read_pct = 90; end
            if (cyc == 900)  begin hold_rdv = 0; read_pct = 50; wait_pct = 0; end
            if (cyc == 1400) begin read_pct = 0; max_wbc = 8; wait_pct = 10; end
            if (cyc == 1520) begin stray = 0; gen_en = 1; read_pct = 50; max_wbc = 4; wait_pct = 25; end
            if (cyc == 1500) begin stray = 1; gen_en = 0; end
            rst_n = !(cyc < 4 || (cyc >= 1500 && cyc < 1504));
            if (!rst_n) begin
                model_reset();
                slave_beats = 0;
            end
            drive_cycle();
            @(negedge clk);
            check_and_step();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
